ahb_dmem_slave: RTL

AHB_DMEM_SLAVE -- requirements
Module: ahb_dmem_slave

---
 rtl/ahb_dmem_pkg.sv | 50 +++++
 rtl/ahb_dmem_align.sv | 55 +++++
 rtl/ahb_dmem_slave.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ahb_dmem_pkg.sv
// Shared definitions for the AHB data-memory slave: rwtyp (funct3) encodings,
// FSM states, wait-counter width, captured request record and legality check.
package ahb_dmem_pkg;

    localparam int WAIT_CNT_W = 3;

    // Load encodings (funct3 of the RISC-V load instructions)
    localparam logic [2:0] RW_LB  = 3'b000;
    localparam logic [2:0] RW_LH  = 3'b001;
    localparam logic [2:0] RW_LW  = 3'b010;
    localparam logic [2:0] RW_LBU = 3'b100;
    localparam logic [2:0] RW_LHU = 3'b101;

    // Store encodings (funct3 of the RISC-V store instructions)
    localparam logic [2:0] RW_SB  = 3'b000;
    localparam logic [2:0] RW_SH  = 3'b001;
    localparam logic [2:0] RW_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MEM  = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    // Bus fields captured in the start cycle
    typedef struct packed {
        logic [2:0]  rwtyp;
        logic [1:0]  off;
        logic        wr;
        logic [31:0] wdata;
    } req_t;

    // True for misaligned halfword/word accesses and undefined rwtyp codes
    function automatic logic xfer_illegal(input logic [2:0] rwtyp,
                                          input logic [1:0] off,
                                          input logic       wr);
        logic bad;
        case (rwtyp)
            RW_LB:   bad = 1'b0;
            RW_LH:   bad = off[0];
            RW_LW:   bad = (off != 2'b00);
            RW_LBU:  bad = wr;
            RW_LHU:  bad = wr | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_dmem_align.sv
// Byte-lane logic for the data-memory slave: store strobes and lane
// replication, load lane extraction with sign/zero extension. Purely
// combinational; misaligned offsets are truncated and unknown codes act as word.
module ahb_dmem_align
    import ahb_dmem_pkg::*;
(
    input  logic [2:0]  rwtyp,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wlane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Store side: strobe from size/offset, data replicated across all lanes
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wstrb = 4'b1111;
        wlane = wdata;
        case (rwtyp)
            RW_SB: begin
                wstrb = 4'b0001 << off;
                wlane = {4{wdata[7:0]}};
            end
            RW_SH: begin
                wstrb = 4'b0011 << {off[1], 1'b0};
                wlane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then extend to 32 bits
    always_comb begin
        case (off)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = off[1] ? rdata[31:16] : rdata[15:0];
        case (rwtyp)
            RW_LB:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            RW_LBU:  rdata_ext = {24'h0, rd_byte};
            RW_LH:   rdata_ext = {{16{rd_half[15]}}, rd_half};
            RW_LHU:  rdata_ext = {16'h0, rd_half};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/ahb_dmem_slave.sv
// AHB-style data-memory slave bridging a simple master handshake to a
// synchronous single-port SRAM. FSM: IDLE -> WAIT (WAIT_CYC cycles) -> MEM -> RSP.
// Optional macro AHB_DMEM_ALIGN_CHK_EN: illegal transfers answer with an error
// response in one cycle without touching the SRAM.
module ahb_dmem_slave
    import ahb_dmem_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       haddr_m2s,
    input  logic              haddr_ctrl_m2s,
    input  logic              hwrite_m2s,
    input  logic [31:0]       hwdata_m2s,
    output logic [31:0]       hdata_s2m,
    output logic              hready_s2m,
    output logic              hresp_s2m,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e                state_q, state_d;
    logic                  ctrl_q;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    req_t                  req_q, req_d, live_req, cur_req;
    logic [ADDR_W-1:0]     widx_q, widx_d, cur_widx;
    logic                  hready_q, hready_d;
    logic                  hresp_q, hresp_d;
    logic                  mem_en_q, mem_en_d;
    logic [3:0]            mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  start, err_start;
    logic [3:0]            lane_wstrb;
    logic [31:0]           lane_wdata, lane_rdata;
    logic                  unused_haddr;

    assign live_req = '{rwtyp: haddr_m2s[29:27], off: haddr_m2s[1:0],
                        wr: hwrite_m2s, wdata: hwdata_m2s};
    assign unused_haddr = ^{haddr_m2s[31:30], haddr_m2s[26:ADDR_W+2]};

    // Rising edge of the address-phase valid, honoured only while idle
    assign start = haddr_ctrl_m2s & ~ctrl_q & (state_q == ST_IDLE);

    // Live bus fields in the start cycle, captured copies for the rest of the transfer
    always_comb begin
        cur_req  = req_q;
        cur_widx = widx_q;
        if (state_q == ST_IDLE) begin
            cur_req  = live_req;
            cur_widx = haddr_m2s[ADDR_W+1:2];
        end
    end

`ifdef AHB_DMEM_ALIGN_CHK_EN
    assign err_start = start & xfer_illegal(cur_req.rwtyp, cur_req.off, cur_req.wr);
`else
    assign err_start = 1'b0;
`endif

    ahb_dmem_align u_align (
        .rwtyp     (cur_req.rwtyp),
        .off       (cur_req.off),
        .wdata     (cur_req.wdata),
        .rdata     (mem_rdata),
        .wstrb     (lane_wstrb),
        .wlane     (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Next-state, wait counter, request capture and registered-output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        widx_d  = widx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    req_d  = live_req;
                    widx_d = haddr_m2s[ADDR_W+1:2];
                    if (err_start) begin
                        state_d = ST_RSP;
                    end else if (WAIT_CYC == 0) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT_W'(WAIT_CYC - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_MEM;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_MEM:  state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        mem_en_d    = (state_d == ST_MEM);
        mem_wen_d   = (mem_en_d && cur_req.wr) ? lane_wstrb : 4'b0000;
        mem_wdata_d = (mem_en_d && cur_req.wr) ? lane_wdata : 32'h0;
        mem_addr_d  = mem_en_d ? cur_widx : mem_addr_q;
        hready_d    = (state_d == ST_RSP);
        hresp_d     = err_start;
    end

    // State and output registers, all cleared immediately by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= 1'b0;
            cnt_q       <= '0;
            req_q       <= '0;
            widx_q      <= '0;
            hready_q    <= 1'b0;
            hresp_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            ctrl_q      <= haddr_ctrl_m2s;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            widx_q      <= widx_d;
            hready_q    <= hready_d;
            hresp_q     <= hresp_d;
            mem_en_q    <= mem_en_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign hready_s2m = hready_q;
    assign hresp_s2m  = hresp_q;
    assign mem_en     = mem_en_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    // SRAM data arrives in the RSP cycle, so the load result is steered combinationally
    assign hdata_s2m  = (state_q == ST_RSP && !req_q.wr && !hresp_q) ? lane_rdata : 32'h0;

endmodule
